// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared state type and default parameters for the frequency meter
package freq_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } fm_state_t;

    localparam int unsigned GATE_CYCLES_DEF = 1_000_000;
    localparam int unsigned COUNT_W_DEF     = 24;
    localparam int unsigned SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - multi-stage synchronizer followed by a one-cycle rising-edge detector
module sync_edge_det #(
    parameter int unsigned STAGES = 2
) (
    input  logic clock_i,
    input  logic reset_n_i,
    input  logic async_i,
    output logic edge_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign edge_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated edge counter; FREQ_METER_MAX_HOLD_EN adds a running max_count_o
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int unsigned COUNT_W     = COUNT_W_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic               clock_i,
    input  logic               reset_n_i,
    input  logic               meas_clk_i,
    input  logic               enable_i,
    output logic [COUNT_W-1:0] count_o,
    output logic               valid_o,
    output logic               overflow_o,
`ifdef FREQ_METER_MAX_HOLD_EN
    output logic [COUNT_W-1:0] max_count_o,
`endif
    output logic               busy_o
);

    localparam int unsigned GATE_W = $clog2(GATE_CYCLES);

    fm_state_t           state, next_state;
    logic [GATE_W-1:0]   gate_cnt;
    logic [COUNT_W-1:0]  edge_cnt;
    logic                sat_seen;
    logic                edge_pulse;
    logic                window_end;
    logic [COUNT_W:0]    sum;
    logic [COUNT_W-1:0]  sat_sum;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_edge (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .async_i   (meas_clk_i),
        .edge_o    (edge_pulse)
    );

    assign window_end = (state == MEASURE) && (gate_cnt == GATE_W'(GATE_CYCLES - 1));
    assign sum        = {1'b0, edge_cnt} + {{COUNT_W{1'b0}}, edge_pulse};
    assign sat_sum    = sum[COUNT_W] ? {COUNT_W{1'b1}} : sum[COUNT_W-1:0];

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) state <= IDLE;
        else            state <= next_state;
    end

    // A window that ends in the same cycle enable drops still publishes before idling.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (enable_i) next_state = MEASURE;
            MEASURE: if (!enable_i) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state == MEASURE);
    end

    // sat_seen keeps overflow sticky once the counter has pinned mid-window.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            sat_seen   <= 1'b0;
            count_o    <= '0;
            overflow_o <= 1'b0;
            valid_o    <= 1'b0;
`ifdef FREQ_METER_MAX_HOLD_EN
            max_count_o <= '0;
`endif
        end else begin
            valid_o <= 1'b0;
            if (state == IDLE || !enable_i || window_end) begin
                gate_cnt <= '0;
                edge_cnt <= '0;
                sat_seen <= 1'b0;
            end else begin
                gate_cnt <= gate_cnt + 1'b1;
                edge_cnt <= sat_sum;
                sat_seen <= sat_seen | sum[COUNT_W];
            end
            if (window_end) begin
                count_o    <= sat_sum;
                overflow_o <= sat_seen | sum[COUNT_W];
                valid_o    <= 1'b1;
            end
`ifdef FREQ_METER_MAX_HOLD_EN
            if (state == IDLE && enable_i)
                max_count_o <= '0;
            else if (window_end && sat_sum > max_count_o)
                max_count_o <= sat_sum;
`endif
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - randomized periodic-input bench for freq_meter against an edges-per-window model
module tb_freq_meter;

    localparam int G = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       meas = 1'b0;
    logic       en = 1'b0;
    logic [7:0] a_count;
    logic       a_valid, a_ovf, a_busy;
    logic [3:0] b_count;
    logic       b_valid, b_ovf, b_busy;
`ifdef FREQ_METER_MAX_HOLD_EN
    logic [7:0] a_max;
    logic [3:0] b_max;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int gen_per = 0;
    int gen_hi = 0;
    int held_a = 0, held_b = 0;
    bit held_ovf_b = 1'b0;
    bit busy_drop = 1'b0;
    int pers[9] = '{0, 2, 4, 5, 10, 20, 25, 50, 100};

    freq_meter #(.GATE_CYCLES(G), .COUNT_W(8), .SYNC_STAGES(2)) dut_a (
        .clock_i(clk), .reset_n_i(rst_n), .meas_clk_i(meas), .enable_i(en),
        .count_o(a_count), .valid_o(a_valid), .overflow_o(a_ovf),
`ifdef FREQ_METER_MAX_HOLD_EN
        .max_count_o(a_max),
`endif
        .busy_o(a_busy)
    );

    freq_meter #(.GATE_CYCLES(G), .COUNT_W(4), .SYNC_STAGES(2)) dut_b (
        .clock_i(clk), .reset_n_i(rst_n), .meas_clk_i(meas), .enable_i(en),
        .count_o(b_count), .valid_o(b_valid), .overflow_o(b_ovf),
`ifdef FREQ_METER_MAX_HOLD_EN
        .max_count_o(b_max),
`endif
        .busy_o(b_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Square wave generator: gen_per cycles per period, gen_hi cycles high; period 0 holds low.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            if (gen_per == 0) begin
                meas = 1'b0;
                ph = 0;
            end else begin
                if (ph >= gen_per) ph = 0;
                meas = (ph < gen_hi);
                ph = ph + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!a_busy) busy_drop = 1'b1;
            if (a_valid) begin
                at = cyc;
                check("valid_b_sync", b_valid, 1);
                break;
            end
        end
        if (at < 0) check("valid_timeout", a_valid, 1);
    endtask

    task automatic measure_steady(input int per, input int hi);
        int t1, t2, t3, exp_edges;
        gen_per = per;
        gen_hi = hi;
        busy_drop = 1'b0;
        wait_valid(250, t1);
        wait_valid(250, t2);
        wait_valid(250, t3);
        exp_edges = (per == 0) ? 0 : G / per;
        check("count_a", a_count, exp_edges);
        check("ovf_a", a_ovf, 0);
        check("count_b", b_count, (exp_edges > 15) ? 15 : exp_edges);
        check("ovf_b", b_ovf, (exp_edges > 15) ? 1 : 0);
        check("valid_spacing", t3 - t2, G);
        check("busy_cont", busy_drop, 0);
        @(negedge clk);
        check("valid_width", a_valid, 0);
        held_a = exp_edges;
        held_b = (exp_edges > 15) ? 15 : exp_edges;
        held_ovf_b = (exp_edges > 15);
    endtask

    task automatic time_first_valid(input string tag);
        int n;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n++;
            if (n == 1) check({tag, "_busy"}, a_busy, 1);
`ifdef FREQ_METER_MAX_HOLD_EN
            if (n == 1 || n == 100) check({tag, "_max_clear"}, a_max, 0);
`endif
            if (a_valid) break;
        end
        check({tag, "_latency"}, n, 101);
    endtask

    task automatic abort_check();
        bit seen;
        seen = 1'b0;
        repeat ($urandom_range(90, 1)) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("abort_busy", a_busy, 0);
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (a_valid || b_valid) seen = 1'b1;
        end
        check("abort_no_valid", seen, 0);
        check("abort_hold_a", a_count, held_a);
        check("abort_hold_b", b_count, held_b);
        check("abort_hold_ovf_b", b_ovf, held_ovf_b);
        en = 1'b1;
        time_first_valid("reenable");
    endtask

    task automatic reset_check();
        repeat ($urandom_range(80, 5)) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_count_a", a_count, 0);
        check("rst_count_b", b_count, 0);
        check("rst_flags_a", {a_valid, a_ovf, a_busy}, 0);
        check("rst_flags_b", {b_valid, b_ovf, b_busy}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        time_first_valid("post_reset");
    endtask

    initial begin
        int per, hi, t;
        repeat (3) @(negedge clk);
        check("reset_count_a", a_count, 0);
        check("reset_flags_a", {a_valid, a_ovf, a_busy}, 0);
        check("reset_count_b", b_count, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", a_busy, 0);
        gen_per = 10;
        gen_hi = 5;
        repeat (5) @(negedge clk);
        en = 1'b1;

        measure_steady(10, 5);
        measure_steady(0, 0);
        measure_steady(2, 1);
        measure_steady(20, 10);
        abort_check();
        reset_check();

        for (int trial = 0; trial < 8; trial++) begin
            per = pers[$urandom_range(8, 0)];
            hi = (per >= 2) ? $urandom_range(per - 1, 1) : 0;
            measure_steady(per, hi);
            if ($urandom_range(2, 0) == 0) abort_check();
        end

`ifdef FREQ_METER_MAX_HOLD_EN
        en = 1'b0;
        gen_per = 10;
        gen_hi = 5;
        repeat (6) @(negedge clk);
        en = 1'b1;
        wait_valid(250, t);
        check("max_p10_count", a_count, 10);
        check("max_p10", a_max, 10);
        gen_per = 0;
        repeat (2) wait_valid(250, t);
        gen_per = 25;
        gen_hi = 12;
        repeat (3) wait_valid(250, t);
        check("max_p25", a_max, 10);
        gen_per = 0;
        repeat (2) wait_valid(250, t);
        gen_per = 5;
        gen_hi = 2;
        repeat (3) wait_valid(250, t);
        check("max_p5", a_max, 20);
        en = 1'b0;
        repeat (5) @(negedge clk);
        en = 1'b1;
        time_first_valid("max_reenable");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Reciprocal-free frequency counter for the DAQ test path. It receives an asynchronous square wave, such as the divided test clock routed back in on a pin, and counts its rising edges over a fixed gate window of GATE_CYCLES system clocks.
- Each window result is published as a count with a one-cycle valid strobe, for display on the hex digits or capture by the logger.
- It is the measuring end of the clock-divider output path, used to confirm divider ratios on hardware.

Parameters:
- GATE_CYCLES, 1_000_000: gate window length in clock_i cycles; minimum 2.
- COUNT_W, 24: width of the edge counter and count_o.
- SYNC_STAGES, 2: flip-flop stages on meas_clk_i before edge detection; minimum 2.

Ports:
- clock_i  input  1  system clock, 100 MHz on board.
- reset_n_i  input  1  asynchronous active-low reset.
- meas_clk_i  input  1  asynchronous signal under measurement.
- enable_i  input  1  level; measurement runs while high.
- count_o  output  COUNT_W  rising edges in the last completed window, saturating.
- valid_o  output  1  one-cycle pulse; count_o updated this cycle.
- overflow_o  output  1  last completed window saturated.
- busy_o  output  1  high while a window is in progress.

Behaviour:
- Reset (async assert, sync deassert by usage): all outputs 0; synchronizer chain 0; gate_cnt 0; edge_cnt 0; state IDLE.
- Edge detect: meas_clk_i passes through SYNC_STAGES flops, then a registered previous value. edge = sync & ~prev, one cycle wide.
- Latency: input edge to edge pulse is SYNC_STAGES+1 cycles.
- Inputs above clock_i/2 alias. This is documented, not detected.
- States:
  - IDLE: busy_o=0, gate_cnt=0, edge_cnt=0. Go to MEASURE on the cycle enable_i is sampled high.
  - MEASURE: busy_o=1. gate_cnt increments from 0 to GATE_CYCLES-1. edge_cnt increments on each edge pulse and saturates at 2^COUNT_W-1. Edges are counted in every window cycle, including cycle 0 and cycle GATE_CYCLES-1.
- Window end (gate_cnt == GATE_CYCLES-1), on the next edge:
  - count_o <= saturating(edge_cnt + edge).
  - overflow_o <= 1 if the true sum exceeds 2^COUNT_W-1, else 0.
  - valid_o <= 1 for one cycle.
  - gate_cnt and edge_cnt restart at 0 and the next window begins the same cycle (back-to-back, no dead cycle) if enable_i is still high. Otherwise go to IDLE.
- enable_i low mid-window: abort on the next edge and go to IDLE. No valid_o. count_o and overflow_o hold their last published values.
- Simultaneous window-end and enable_i low: the window completes and publishes, then IDLE.
- count_o and overflow_o change only on valid_o cycles (and reset).
- Reset mid-window: immediate clear; no partial result published.

Optional Feature:
- Macro: FREQ_METER_MAX_HOLD_EN.
- With it: extra output max_count_o (COUNT_W). It is updated on each valid_o to max(max_count_o, new count) and cleared on reset and on each IDLE->MEASURE transition.
- Without it: the port and register are absent; behaviour is otherwise identical.

Decomposition:
- Package freq_meter_pkg holds:
  - typedef enum logic {IDLE, MEASURE} fm_state_t;
  - localparam defaults for GATE_CYCLES, COUNT_W, SYNC_STAGES.
- Sub-module sync_edge_det(clock_i, reset_n_i, async_i, edge_o) contains the synchronizer chain and the rising-edge detector. It is reused for future button and trigger inputs.

Test Plan:
1. GATE_CYCLES=100, COUNT_W=8; meas_clk_i period 10 clock_i cycles (5 high/5 low); enable_i high. Required: every window after the first gives count_o=10, overflow_o=0, valid_o every 100 cycles exactly.
2. Same config, meas_clk_i held 0. Required: count_o=0 on each valid_o; busy_o stays 1 continuously.
3. COUNT_W=4, GATE_CYCLES=100, meas_clk_i toggling every cycle (50 edges). Required: count_o=15, overflow_o=1. Then switch to period 20: next full window gives count_o=5, overflow_o=0.
4. enable_i dropped at gate_cnt=50. Required: no valid_o; busy_o=0 next cycle; count_o holds its prior value. Re-enable: the first valid_o comes 101 cycles after enable_i is sampled high.
5. reset_n_i pulsed low mid-window, asynchronous to clock_i. Required: all outputs 0 immediately. After release with enable_i high, the first valid_o comes 101 cycles later.
6. FREQ_METER_MAX_HOLD_EN defined; period 10, then 25, then 5 (one window each). Required: max_count_o = 10, 10, 20. After an enable_i drop and re-enable, max_count_o=0 until the next valid_o.
